// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the irq_controller register window and request FSM.
// Build option: IRQ_CTRL_TIMER_EN enables the internal interval timer on source 7.
package irq_ctrl_pkg;

    localparam int NUM_SRC = 8;

    // Pseudo-index used for the vector of an acknowledge with no valid winner.
    localparam logic [3:0] SPURIOUS_IDX = 4'd8;

    // Register offsets inside the 8-word window.
    localparam logic [2:0] OFF_PEND   = 3'd0;
    localparam logic [2:0] OFF_MASK   = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_VBASE  = 3'd3;
    localparam logic [2:0] OFF_EOI    = 3'd4;
    localparam logic [2:0] OFF_RELOAD = 3'd5;
    localparam logic [2:0] OFF_COUNT  = 3'd6;
    localparam logic [2:0] OFF_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_e;

    // Lowest set bit wins; SPURIOUS_IDX when nothing is requesting.
    function automatic logic [3:0] find_winner(input logic [NUM_SRC-1:0] req);
        logic [3:0] idx;
        idx = SPURIOUS_IDX;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_timer.sv
// Interval timer: COUNT runs down from RELOAD and ticks once per RELOAD+1 cycles.
// Only instantiated by irq_controller when IRQ_CTRL_TIMER_EN is defined.
module irq_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_reload_we,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_reload,
    output logic [15:0] o_count,
    output logic        o_tick
);

    logic [15:0] r_reload;
    logic [15:0] r_count;

    // The tick is the cycle in which a running counter sits at zero.
    assign o_tick   = (r_reload != 16'd0) && (r_count == 16'd0);
    assign o_reload = r_reload;
    assign o_count  = r_count;

    // Reload/count registers; a RELOAD write restarts the period immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reload <= 16'd0;
            r_count  <= 16'd0;
        end else if (i_reload_we) begin
            r_reload <= i_wdata;
            r_count  <= i_wdata;
        end else if (r_reload == 16'd0) begin
            r_count  <= 16'd0;
        end else if (o_tick) begin
            r_count  <= r_reload;
        end else begin
            r_count  <= r_count - 16'd1;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Bus-responder interrupt controller: eight edge-triggered sources, lowest index
// wins, vector supplied on the shared data bus during iack, EOI ends service.
// Build option: IRQ_CTRL_TIMER_EN replaces external src[7] with an internal timer.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFE00,
    parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  addr,
    inout  wire  [15:0]  data,
    input  logic         read,
    input  logic         write,
    input  logic         iack,
    input  logic [7:0]   src,
    output logic         irq
);

    state_e      r_state;
    state_e      w_state_next;
    logic        r_irq;
    logic        w_irq_next;
    logic        w_in_service;

    logic [7:0]  r_pend;
    logic [7:0]  r_mask;
    logic [15:0] r_vbase;
    logic [2:0]  r_status_idx;
    logic [7:0]  r_src_q;

    logic        w_hit;
    logic [2:0]  w_off;
    logic        w_rd_hit;
    logic        w_wr_hit;
    logic [15:0] w_wdata;
    logic [7:0]  w_pend_masked;
    logic        w_has_req;
    logic [3:0]  w_win;
    logic        w_ack_valid;
    logic [3:0]  w_vec_idx;
    logic [15:0] w_vector;
    logic [7:0]  w_edges;
    logic [7:0]  w_set;
    logic [7:0]  w_clr;
    logic [7:0]  w_pend_next;
    logic [15:0] w_rdata;
    logic        w_drive;

    assign w_hit    = (addr[15:3] == BASE_ADDR[15:3]);
    assign w_off    = addr[2:0];
    assign w_rd_hit = read  && w_hit;
    assign w_wr_hit = write && w_hit;
    assign w_wdata  = data;

    assign w_pend_masked = r_pend & r_mask;
    assign w_has_req     = |w_pend_masked;
    assign w_win         = find_winner(w_pend_masked);
    // A real acknowledge needs a live winner; anything else gets the spurious vector.
    assign w_ack_valid   = iack && (r_state == REQ) && w_has_req;
    assign w_vec_idx     = w_ack_valid ? w_win : SPURIOUS_IDX;
    assign w_vector      = r_vbase + {12'd0, w_vec_idx};

    assign w_edges = src & ~r_src_q;

`ifdef IRQ_CTRL_TIMER_EN
    logic [15:0] w_reload;
    logic [15:0] w_count;
    logic        w_tick;

    irq_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_reload_we (w_wr_hit && (w_off == OFF_RELOAD)),
        .i_wdata     (w_wdata),
        .o_reload    (w_reload),
        .o_count     (w_count),
        .o_tick      (w_tick)
    );

    // Source 7 belongs to the timer; the external pin is not looked at.
    assign w_set = {w_tick, w_edges[6:0]};
`else
    assign w_set = w_edges;
`endif

    // Clears come from a W1C write and from an accepted acknowledge; sets override both.
    assign w_clr = ((w_wr_hit && (w_off == OFF_PEND)) ? w_wdata[7:0] : 8'd0)
                 | (w_ack_valid ? (8'd1 << w_win[2:0]) : 8'd0);
    assign w_pend_next = (r_pend & ~w_clr) | w_set;

    // State register; irq is a flop so the CPU never sees a decode glitch.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_irq   <= w_irq_next;
        end
    end

    // Next-state logic: request, acknowledge, end-of-interrupt.
    always_comb begin
        // NOTE: default first so no path leaves w_state_next unassigned (no latch).
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_has_req) w_state_next = REQ;
            end
            REQ: begin
                if (w_ack_valid)     w_state_next = SERVICE;
                else if (!w_has_req) w_state_next = IDLE;
            end
            SERVICE: begin
                if (w_wr_hit && (w_off == OFF_EOI)) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs derived from the state: next irq value and the in-service flag.
    always_comb begin
        w_irq_next   = (w_state_next == REQ);
        w_in_service = (r_state == SERVICE);
    end

    assign irq = r_irq;

    // Datapath registers: edge history, pending, mask, vector base, status index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_q      <= 8'd0;
            r_pend       <= 8'd0;
            r_mask       <= 8'd0;
            r_vbase      <= VECTOR_BASE;
            r_status_idx <= 3'd0;
        end else begin
            r_src_q <= src;
            r_pend  <= w_pend_next;
            if (w_wr_hit && (w_off == OFF_MASK))  r_mask  <= w_wdata[7:0];
            if (w_wr_hit && (w_off == OFF_VBASE)) r_vbase <= w_wdata;
            if (w_ack_valid) r_status_idx <= w_win[2:0];
        end
    end

    // Register read mux; unused and write-only offsets read as zero.
    always_comb begin
        w_rdata = 16'd0;
        case (w_off)
            OFF_PEND:   w_rdata = {8'd0, r_pend};
            OFF_MASK:   w_rdata = {8'd0, r_mask};
            OFF_STATUS: w_rdata = {w_in_service, 12'd0, r_status_idx};
            OFF_VBASE:  w_rdata = r_vbase;
`ifdef IRQ_CTRL_TIMER_EN
            OFF_RELOAD: w_rdata = w_reload;
            OFF_COUNT:  w_rdata = w_count;
`endif
            default:    w_rdata = 16'd0;
        endcase
    end

    // iack owns the bus over a read; reset releases it without waiting for an edge.
    assign w_drive = !reset && (iack || w_rd_hit);
    assign data    = w_drive ? (iack ? w_vector : w_rdata) : 16'hzzzz;

endmodule
